score_bcd_digits: RTL and testbench



---
 rtl/score_bcd_digits.sv | 150 +++++++++++++++
 tb/tb_score_bcd_digits.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_digits.sv
// score_bcd_digits: sequential binary-to-BCD converter (shift-add-3) feeding the
// per-digit seven-segment decoders, one nibble per display.
// Latency: digits/done appear BIN_WIDTH+1 edges after the accepted start edge.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped.
//
// Ports:
//   clock    - system clock, rising edge
//   reset    - synchronous active-high reset (aborts any conversion)
//   start    - conversion request, sampled in IDLE only
//   value    - unsigned binary score, latched on the accepted start edge
//   busy     - high while a conversion is in flight (SHIFT and DONE states)
//   done     - one-cycle pulse when digits/overflow are refreshed
//   digits   - BCD result, [3:0] ones ... [4*DIGITS-1:4*DIGITS-4] most significant
//   overflow - last value exceeded 10^DIGITS-1; digits saturated to all 9s
module score_bcd_digits #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  overflow
);

    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    function automatic longint unsigned pow10_minus1(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    localparam longint unsigned MAX_VAL = pow10_minus1(DIGITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [BIN_WIDTH-1:0] r_bin;
    logic [BW-1:0]        r_bcd;
    logic [CW-1:0]        r_count;
    logic                 r_ovf_pending;
    logic [BW-1:0]        r_digits;
    logic                 r_overflow;
    logic                 r_done;

    logic [BW-1:0]        w_bcd_adj;
    logic                 w_last_step;
    logic                 w_value_ovf;
    logic                 w_busy;

    // Final step is the one that brings the count up to BIN_WIDTH.
    assign w_last_step = (r_count == CW'(BIN_WIDTH - 1));

    // Zero-extend to 64 bits so the range test is exact for any BIN_WIDTH <= 64.
    assign w_value_ovf = (64'(value) > MAX_VAL);

    // Add-3 correction, every nibble evaluated from the current work register.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start)       w_next_state = S_SHIFT;
            S_SHIFT: if (w_last_step) w_next_state = S_DONE;
            S_DONE:                   w_next_state = S_IDLE;
            default:                  w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_busy = (r_state == S_SHIFT) || (r_state == S_DONE);
    end

    // Datapath and registered results
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bin         <= '0;
            r_bcd         <= '0;
            r_count       <= '0;
            r_ovf_pending <= 1'b0;
            r_digits      <= '0;
            r_overflow    <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bin         <= value;
                        r_bcd         <= '0;
                        r_count       <= '0;
                        r_ovf_pending <= w_value_ovf;
                    end
                end
                S_SHIFT: begin
                    // Top BCD bit falls off; for out-of-range values the upper
                    // digits get corrupted, but saturation replaces them anyway.
                    {r_bcd, r_bin} <= {w_bcd_adj[BW-2:0], r_bin, 1'b0};
                    r_count        <= r_count + CW'(1);
                end
                S_DONE: begin
                    r_digits   <= r_ovf_pending ? {DIGITS{4'h9}} : r_bcd;
                    r_overflow <= r_ovf_pending;
                    r_done     <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = w_busy;
    assign done     = r_done;
    assign digits   = r_digits;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_score_bcd_digits.sv
// Self-checking bench for score_bcd_digits: table vectors, random values against a
// decimal reference model, and hand sequences for ignored start, reset abort and
// continuously held start.
module tb_score_bcd_digits;

    logic        clock;
    logic        reset;
    logic        start;
    logic [13:0] value;
    logic        busy;
    logic        done;
    logic [15:0] digits;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    score_bcd_digits #(.BIN_WIDTH(14), .DIGITS(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .digits   (digits),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          v;
        logic [15:0] d;
        logic        o;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain decimal arithmetic with saturation at 9999.
    function automatic logic [15:0] model_digits(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic model_ovf(input int v);
        return v > 9999;
    endfunction

    // One full conversion from IDLE; checks latency, busy, results and done width.
    task automatic run_conv(input int v, input logic [15:0] exp_d, input logic exp_o, input string name);
        int n;
        bit got;
        bit busy_bad;
        @(negedge clock);
        start = 1'b1;
        value = 14'(v);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        n = 0;
        got = 0;
        busy_bad = !busy;
        while (n < 40 && !got) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (done) got = 1;
            else if (!busy) busy_bad = 1;
        end
        chk({name, " latency"}, n, 15);
        chk({name, " busy"}, {31'd0, busy_bad}, 0);
        chk({name, " busy_at_done"}, {31'd0, busy}, 0);
        chk({name, " digits"}, digits, exp_d);
        chk({name, " overflow"}, {31'd0, overflow}, {31'd0, exp_o});
        @(negedge clock);
        chk({name, " done_width"}, {31'd0, done}, 0);
    endtask

    initial begin
        int n;
        int ndone;
        bit got;
        int v;
        int vals[2];
        logic prev_done;

        tbl[0] = '{v: 0,     d: 16'h0000, o: 1'b0};
        tbl[1] = '{v: 1234,  d: 16'h1234, o: 1'b0};
        tbl[2] = '{v: 9999,  d: 16'h9999, o: 1'b0};
        tbl[3] = '{v: 10000, d: 16'h9999, o: 1'b1};
        tbl[4] = '{v: 16383, d: 16'h9999, o: 1'b1};
        tbl[5] = '{v: 42,    d: 16'h0042, o: 1'b0};
        tbl[6] = '{v: 1000,  d: 16'h1000, o: 1'b0};
        tbl[7] = '{v: 7,     d: 16'h0007, o: 1'b0};

        reset = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset done", {31'd0, done}, 0);
        chk("reset digits", digits, 0);
        chk("reset overflow", {31'd0, overflow}, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_conv(tbl[i].v, tbl[i].d, tbl[i].o, $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) v = $urandom_range(9990, 10010);
            else            v = $urandom_range(0, 16383);
            run_conv(v, model_digits(v), model_ovf(v), $sformatf("rnd%0d_v%0d", i, v));
        end

        // start pulses at edges 3 and 7 during a conversion must be dropped
        @(negedge clock);
        start = 1'b1;
        value = 14'd500;
        @(posedge clock);
        @(negedge clock);
        n = 0;
        got = 0;
        while (n < 40 && !got) begin
            start = (n + 1 == 3) || (n + 1 == 7);
            value = start ? 14'd77 : 14'd500;
            @(posedge clock);
            n++;
            @(negedge clock);
            if (done) got = 1;
        end
        start = 1'b0;
        chk("ignore latency", n, 15);
        chk("ignore digits", digits, 16'h0500);
        chk("ignore overflow", {31'd0, overflow}, 0);
        ndone = 0;
        repeat (20) begin
            @(posedge clock);
            @(negedge clock);
            if (done) ndone++;
        end
        chk("ignore no_extra_done", ndone, 0);

        // reset at edge 6 aborts the conversion
        start = 1'b1;
        value = 14'd321;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        ndone = 0;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) ndone++;
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("abort busy", {31'd0, busy}, 0);
        chk("abort done", {31'd0, done}, 0);
        chk("abort digits", digits, 0);
        chk("abort overflow", {31'd0, overflow}, 0);
        reset = 1'b0;
        repeat (20) begin
            @(posedge clock);
            @(negedge clock);
            if (done) ndone++;
        end
        chk("abort no_done", ndone, 0);
        run_conv(8, 16'h0008, 1'b0, "after_abort");

        // start held high, value swapped right after each acceptance
        vals[0] = 12;
        vals[1] = 3456;
        start = 1'b1;
        value = 14'(vals[0]);
        prev_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("held%0d done_low_after_accept", k), {31'd0, done}, 0);
            value = 14'(vals[(k + 1) % 2]);
            n = 0;
            got = 0;
            while (n < 40 && !got) begin
                @(posedge clock);
                n++;
                @(negedge clock);
                if (done && prev_done) got = 0;
                prev_done = done;
                if (done) got = 1;
            end
            chk($sformatf("held%0d latency", k), n, 15);
            chk($sformatf("held%0d digits", k), digits, model_digits(vals[k % 2]));
        end
        start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
